// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - state encoding and address-field width helpers shared by the icache_burst files
package icache_pkg;

    typedef enum logic [1:0] {IDLE, AREQ, FILL} state_t;

    function automatic int word_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int awidth, input int lines, input int words);
        return awidth - 2 - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// rtl/icache_data_ram.sv - line data storage: one-word synchronous write, asynchronous read
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int LINES = 256,
    parameter int WORDS = 4,
    parameter int DWIDTH = 32,
    localparam int WB = word_bits(WORDS),
    localparam int IB = index_bits(LINES)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IB-1:0]     wr_index,
    input  logic [WB-1:0]     wr_word,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [IB-1:0]     rd_index,
    input  logic [WB-1:0]     rd_word,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [LINES*WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[{wr_index, wr_word}] <= wr_data;
    end

    assign rd_data = mem[{rd_index, rd_word}];

endmodule

// File: rtl/icache_burst.sv
// rtl/icache_burst.sv - direct-mapped instruction cache with one-burst line refill and whole-cache flush
// Defining ICACHE_PERF_EN adds the hit_count/miss_count ports.
module icache_burst
    import icache_pkg::*;
#(
    parameter int LINES  = 256,
    parameter int WORDS  = 4,
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int LWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic              req,
    input  logic              flush,
    output logic [DWIDTH-1:0] data,
    output logic              valid,
    output logic              busy,
    output logic [AWIDTH-1:0] ram_araddr,
    output logic [LWIDTH-1:0] ram_arlen,
    output logic              ram_arvalid,
    input  logic              ram_arready,
    input  logic [DWIDTH-1:0] ram_rdata,
    input  logic              ram_rvalid,
    output logic              ram_rready,
    input  logic              ram_rlast
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int WB  = word_bits(WORDS);
    localparam int IB  = index_bits(LINES);
    localparam int TB  = tag_bits(AWIDTH, LINES, WORDS);
    localparam int LAW = TB + IB;

    state_t            state;
    logic [LINES-1:0]  line_valid;
    logic [TB-1:0]     tags [LINES];
    logic [LAW-1:0]    line_q;
    logic [WB-1:0]     cnt;
    logic              over;
    logic              flush_pending;

    logic [WB-1:0]     req_word;
    logic [IB-1:0]     req_index;
    logic [TB-1:0]     req_tag;
    logic [IB-1:0]     fill_index;
    logic [TB-1:0]     fill_tag;
    logic [DWIDTH-1:0] rd_data;
    logic              lookup_hit, hit, miss, beat, last_word;
    logic              unused_byte_bits;

    assign req_word   = addr[2 +: WB];
    assign req_index  = addr[2+WB +: IB];
    assign req_tag    = addr[AWIDTH-1 -: TB];
    assign fill_index = line_q[IB-1:0];
    assign fill_tag   = line_q[LAW-1 -: TB];
    assign unused_byte_bits = ^addr[1:0];

    assign lookup_hit = line_valid[req_index] && (tags[req_index] == req_tag);
    assign hit        = (state == IDLE) && req && !flush && lookup_hit;
    assign miss       = (state == IDLE) && req && !flush && !lookup_hit;
    assign beat       = ram_rready && ram_rvalid;
    assign last_word  = (cnt == WB'(WORDS - 1));

    assign valid = hit;
    assign data  = hit ? rd_data : '0;
    assign busy  = (state != IDLE) || flush_pending;

    // Beats past the last word of an overlong burst are drained without being written.
    icache_data_ram #(.LINES(LINES), .WORDS(WORDS), .DWIDTH(DWIDTH)) u_data (
        .clk      (clk),
        .we       (beat && !over),
        .wr_index (fill_index),
        .wr_word  (cnt),
        .wr_data  (ram_rdata),
        .rd_index (req_index),
        .rd_word  (req_word),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk) begin
        if (beat && ram_rlast) tags[fill_index] <= fill_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            line_valid    <= '0;
            line_q        <= '0;
            cnt           <= '0;
            over          <= 1'b0;
            flush_pending <= 1'b0;
            ram_araddr    <= '0;
            ram_arlen     <= '0;
            ram_arvalid   <= 1'b0;
            ram_rready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        line_valid <= '0;
                    end else if (miss) begin
                        // The victim is invalidated up front so a failed refill cannot expose mixed data.
                        line_q                <= addr[AWIDTH-1 -: LAW];
                        line_valid[req_index] <= 1'b0;
                        ram_araddr            <= {addr[AWIDTH-1 -: LAW], {(WB+2){1'b0}}};
                        ram_arlen             <= LWIDTH'(WORDS - 1);
                        ram_arvalid           <= 1'b1;
                        state                 <= AREQ;
                    end
                end
                AREQ: begin
                    if (flush) flush_pending <= 1'b1;
                    if (ram_arready) begin
                        ram_arvalid <= 1'b0;
                        ram_rready  <= 1'b1;
                        cnt         <= '0;
                        over        <= 1'b0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (flush) flush_pending <= 1'b1;
                    if (beat) begin
                        if (ram_rlast) begin
                            ram_rready    <= 1'b0;
                            flush_pending <= 1'b0;
                            state         <= IDLE;
                            if (flush || flush_pending) line_valid <= '0;
                            else if (last_word && !over) line_valid[fill_index] <= 1'b1;
                        end else if (last_word) begin
                            over <= 1'b1;
                        end else begin
                            cnt <= cnt + WB'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (req && valid) hit_count <= hit_count + 32'd1;
            if (miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_burst.sv
// tb/tb_icache_burst.sv - randomized self-checking bench for icache_burst against a line-level cache model
module tb_icache_burst;

    localparam int LINES  = 16;
    localparam int WORDS  = 4;
    localparam int AWIDTH = 32;
    localparam int LWIDTH = 8;
    localparam int LBYTES = WORDS * 4;

    logic        clk = 1'b0;
    logic        rst, req, flush;
    logic [31:0] addr, data;
    logic        valid, busy;
    logic [31:0] ram_araddr, ram_rdata;
    logic [7:0]  ram_arlen;
    logic        ram_arvalid, ram_arready, ram_rvalid, ram_rready, ram_rlast;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_burst #(.LINES(LINES), .WORDS(WORDS), .AWIDTH(AWIDTH), .DWIDTH(32), .LWIDTH(LWIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .req         (req),
        .flush       (flush),
        .data        (data),
        .valid       (valid),
        .busy        (busy),
        .ram_araddr  (ram_araddr),
        .ram_arlen   (ram_arlen),
        .ram_arvalid (ram_arvalid),
        .ram_arready (ram_arready),
        .ram_rdata   (ram_rdata),
        .ram_rvalid  (ram_rvalid),
        .ram_rready  (ram_rready),
        .ram_rlast   (ram_rlast)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    bit          mvalid [LINES];
    int unsigned mline [LINES];
    int unsigned exp_hits, exp_misses;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int unsigned ln = a / LBYTES;
        return mvalid[ln % LINES] && (mline[ln % LINES] == ln);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endfunction

    // Plays the RAM slave for one burst; flush_beat < 0 means no flush pulse.
    task automatic refill(input logic [31:0] base, input int nbeats, input int flush_beat,
                          input int ar_delay, input bit gaps);
        int b = 0;
        int budget = 0;
        int unsigned ln = base / LBYTES;
        for (int i = 0; i <= ar_delay; i++) begin
            @(negedge clk);
            ram_arready = (i == ar_delay);
            #1;
            checks++;
            if (ram_arvalid !== 1'b1 || ram_araddr !== base || ram_arlen !== 8'(WORDS - 1) ||
                valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL areq: arvalid=%b araddr=%h arlen=%0d valid=%b busy=%b, required 1 %h %0d 0 1",
                         ram_arvalid, ram_araddr, ram_arlen, valid, busy, base, WORDS - 1);
            end
        end
        while (b < nbeats && budget < 100) begin
            @(negedge clk);
            ram_arready = 1'b0;
            ram_rvalid  = !(gaps && $urandom_range(0, 2) == 0);
            ram_rdata   = ram_word(base + 32'(4 * b));
            ram_rlast   = (b == nbeats - 1);
            flush       = ram_rvalid && (b == flush_beat);
            #1;
            checks++;
            if (ram_rready !== 1'b1 || ram_arvalid !== 1'b0 || valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL fill beat %0d: rready=%b arvalid=%b valid=%b busy=%b, required 1 0 0 1",
                         b, ram_rready, ram_arvalid, valid, busy);
            end
            if (ram_rvalid) b++;
            budget++;
        end
        if (budget >= 100) begin
            failures++;
            $display("FAIL fill timeout: beats=%0d, required %0d", b, nbeats);
        end
        @(negedge clk);
        ram_rvalid = 1'b0;
        ram_rlast  = 1'b0;
        flush      = 1'b0;
        if (flush_beat >= 0 && flush_beat < nbeats) model_clear();
        else if (nbeats == WORDS) begin
            mvalid[ln % LINES] = 1'b1;
            mline[ln % LINES]  = ln;
        end
    endtask

    // Holds req on a until it hits; the first refill uses the given burst shape, retries are clean.
    task automatic access(input logic [31:0] a, input int nbeats, input int flush_beat,
                          input int ar_delay, input bit gaps);
        bit h;
        int tries = 0;
        int unsigned ln = a / LBYTES;
        @(negedge clk);
        addr  = a;
        req   = 1'b1;
        flush = 1'b0;
        forever begin
            #1;
            h = model_hit(a);
            checks++;
            if (valid !== h || data !== (h ? ram_word(a) : 32'd0) || busy !== 1'b0) begin
                failures++;
                $display("FAIL lookup %h: valid=%b data=%h busy=%b, required %b %h 0",
                         a, valid, data, busy, h, h ? ram_word(a) : 32'd0);
            end
            if (h || tries == 3) break;
            exp_misses++;
            mvalid[ln % LINES] = 1'b0;
            if (tries == 0) refill(a & ~32'(LBYTES - 1), nbeats, flush_beat, ar_delay, gaps);
            else refill(a & ~32'(LBYTES - 1), WORDS, -1, 0, 1'b1);
            tries++;
        end
        if (h) exp_hits++;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b1; addr = 32'h100; flush = 1'b0;
        ram_arready = 1'b0; ram_rvalid = 1'b0; ram_rlast = 1'b0; ram_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ram_arvalid !== 1'b0 || ram_rready !== 1'b0 || ram_araddr !== 32'd0 || ram_arlen !== 8'd0 ||
            valid !== 1'b0 || data !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: arvalid=%b rready=%b araddr=%h arlen=%0d valid=%b data=%h busy=%b, required all 0",
                     ram_arvalid, ram_rready, ram_araddr, ram_arlen, valid, data, busy);
        end
`ifdef ICACHE_PERF_EN
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            failures++;
            $display("FAIL reset counters: hit=%0d miss=%0d, required 0 0", hit_count, miss_count);
        end
`endif
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
    endtask

    task automatic test_line_fill;
        access(32'h100, WORDS, -1, 0, 1'b0);
        for (int w = 1; w < WORDS; w++) access(32'h100 + 32'(4 * w), WORDS, -1, 0, 1'b0);
        test_reset();
        access(32'h108, WORDS, -1, 1, 1'b0);
    endtask

    task automatic test_eviction;
        access(32'h100, WORDS, -1, 0, 1'b1);
        access(32'h100 + 32'(LINES * LBYTES), WORDS, -1, 2, 1'b1);
        access(32'h100, WORDS, -1, 0, 1'b1);
    endtask

    task automatic test_flush;
        test_reset();
        access(32'h100, WORDS, 1, 0, 1'b0);
`ifdef ICACHE_PERF_EN
        @(negedge clk); req = 1'b0; #1;
        checks++;
        if (miss_count !== 32'd2) begin
            failures++;
            $display("FAIL flush miss_count: got %0d, required 2", miss_count);
        end
`endif
        access(32'h140, WORDS, -1, 0, 1'b1);
        @(negedge clk);
        addr = 32'h140; req = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || data !== 32'd0) begin
            failures++;
            $display("FAIL idle flush: valid=%b data=%h, required 0 0", valid, data);
        end
        model_clear();
        access(32'h140, WORDS, -1, 0, 1'b1);
    endtask

    task automatic test_bad_bursts;
        access(32'h180, 2, -1, 0, 1'b0);
        access(32'h1C0, WORDS + 2, -1, 1, 1'b1);
        access(32'h184, WORDS, -1, 0, 1'b1);
    endtask

    task automatic test_reset_mid_fill;
        @(negedge clk);
        addr = 32'h300; req = 1'b1; flush = 1'b0;
        #1;
        @(negedge clk);
        ram_arready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ram_arready = 1'b0; ram_rvalid = 1'b1; ram_rlast = 1'b0;
            ram_rdata = ram_word(32'h300 + 32'(4 * i));
        end
        @(negedge clk);
        rst = 1'b1;
        ram_rdata = ram_word(32'h308);
        @(negedge clk);
        #1;
        checks++;
        if (ram_rready !== 1'b0 || ram_arvalid !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset mid-fill: rready=%b arvalid=%b valid=%b busy=%b, required 0 0 0 0",
                     ram_rready, ram_arvalid, valid, busy);
        end
        @(negedge clk);
        rst = 1'b0; req = 1'b0; ram_rvalid = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
        access(32'h300, WORDS, -1, 0, 1'b1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                req   = 1'b0;
                flush = ($urandom_range(0, 1) == 1);
                #1;
                checks++;
                if (valid !== 1'b0 || data !== 32'd0) begin
                    failures++;
                    $display("FAIL idle cycle: valid=%b data=%h, required 0 0", valid, data);
                end
                if (flush) model_clear();
            end else begin
                int r = $urandom_range(0, 19);
                int nb = (r == 0) ? $urandom_range(1, WORDS - 1) : (r == 1) ? WORDS + $urandom_range(1, 2) : WORDS;
                int fb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, nb - 1) : -1;
                access(32'($urandom_range(0, 4 * LINES * WORDS - 1)) << 2, nb, fb, $urandom_range(0, 2), 1'b1);
            end
        end
        @(negedge clk);
        req = 1'b0; flush = 1'b0;
        #1;
`ifdef ICACHE_PERF_EN
        checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses) begin
            failures++;
            $display("FAIL perf counters: hit=%0d miss=%0d, required %0d %0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_line_fill();
        test_eviction();
        test_flush();
        test_bad_bursts();
        test_reset_mid_fill();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_burst.md
# icache_burst

Direct-mapped, read-only instruction cache with multi-word lines, parametrised geometry, burst line refill and whole-cache invalidate. It sits between the fetch stage and the instruction RAM read channel and answers hits combinationally in the request cycle. Misses are serviced by a single AXI-style read burst of one full line.

## Interface
Parameters:
- `LINES`, 256: number of cache lines; power of two, at least 2.
- `WORDS`, 4: 32-bit words per line; power of two, at least 2.
- `AWIDTH`, 32: address width.
- `DWIDTH`, 32: data width; fixed at 32.
- `LWIDTH`, 8: burst-length field width; must satisfy `WORDS-1 < 2^LWIDTH`.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `addr` in AWIDTH: fetch byte address.
- `req` in 1: fetch request.
- `flush` in 1: one-cycle pulse; invalidate the whole cache (fence.i).
- `data` out 32: instruction word; 0 when `valid` is low.
- `valid` out 1: hit; `data` is valid this cycle.
- `busy` out 1: high in any state other than IDLE, or while a flush is pending.
- `ram_araddr` out AWIDTH: line-aligned burst address.
- `ram_arlen` out LWIDTH: burst length, always `WORDS-1`.
- `ram_arvalid` out 1; `ram_arready` in 1.
- `ram_rdata` in 32; `ram_rvalid` in 1; `ram_rready` out 1; `ram_rlast` in 1.
- `hit_count`, `miss_count` out 32 each: present only with `ICACHE_PERF_EN`.

## Operation
- Address split: bits [1:0] are the byte offset and are ignored. Then come log2(WORDS) word bits, then log2(LINES) index bits. The remaining upper bits form the tag.
- Valid bits are flops. Tag and data arrays have no reset.
- Hit: `req`, state IDLE, valid bit set, and tag equal. Then `valid=1` and `data=word[index][word]`, both combinational.
- **IDLE**:
  - On a miss with `req`: latch the line address and go to AREQ.
  - On `flush`: clear all valid bits in one cycle. `valid` is 0 during that cycle.
- **AREQ**:
  - Outputs: `ram_arvalid=1`, `ram_araddr` = line base (word and byte bits zero), `ram_arlen=WORDS-1`.
  - On `ram_arready`: go to FILL and clear the beat counter.
- **FILL**:
  - `ram_rready=1`.
  - Each `ram_rvalid` beat writes `data[index][cnt]` and increments `cnt`.
  - On a beat with `ram_rlast`:
    - If `cnt==WORDS-1` and no flush is pending: write the tag and set the valid bit.
    - Return to IDLE.
  - A short burst (`ram_rlast` early) or a long burst (no `rlast` at `WORDS-1`) leaves the line invalid.
  - A long burst: stop counting, drain beats until `rlast`, then return to IDLE.
- `valid` is 0 in AREQ and FILL. The fetch stage holds `addr` and `req` stable until `valid`.
- `flush` during AREQ or FILL sets a pending flag:
  - The burst completes.
  - The refilled line is not validated.
  - All valid bits are cleared on the return to IDLE.
- `req` dropping mid-refill does not abort the burst.

## Timing
- Reset values: `ram_arvalid=0`, `ram_rready=0`, `ram_araddr=0`, `ram_arlen=0`, all valid bits 0, state IDLE, counters 0.
- Because all valid bits are 0 after reset, `valid=0` and `data=0`.
- Reset mid-burst: drop immediately to IDLE. Beats still in flight are ignored, since `rready=0`.
- Hit latency: 0 cycles.
- Miss timeline, with `arready` and `rvalid` always high:
  - Miss detected at cycle T.
  - `arvalid` at T+1.
  - Beats at T+2 through T+1+WORDS.
  - Hit at T+2+WORDS.
- Handshakes:
  - `ram_arvalid` is held until `ram_arready`; address and length are stable while it is held.
  - A beat transfers on `rvalid & rready`.

## Configuration
- Macro `ICACHE_PERF_EN`.
- Defined:
  - 32-bit wrapping `hit_count` increments on each cycle with `req & valid`.
  - `miss_count` increments on each IDLE→AREQ transition.
  - Both counters reset to 0 on `rst`. `flush` does not clear them.
- Undefined: the ports and logic are absent. All other behaviour is identical.

## Structure
- `icache_pkg` holds:
  - the state enum (IDLE, AREQ, FILL);
  - the `WORD_BITS`, `INDEX_BITS` and `TAG_BITS` localparam derivation functions.
- Sub-module `icache_data_ram`: LINES×WORDS×32 array with a one-word synchronous write and an asynchronous read. The top level holds the tags, valid bits and FSM.

## Test plan
- Reset, then `req` at 0x100 with WORDS=4 → `valid=0`, `arvalid` next cycle, `araddr=0x100`, `arlen=3`. Four beats A0..A3 → 0x100..0x10C hit with A0..A3.
- Request 0x108 on a cold line → `araddr=0x100`. After the fill, 0x108 returns beat 2 with zero cycles of latency.
- Fill 0x100, then fill an address with the same index and a different tag (0x100 + LINES·16) → the second fill evicts the first, and a re-request of 0x100 misses.
- `flush` pulse during FILL → the burst completes and `valid` stays 0 on return. Re-request → miss; with PERF enabled, `miss_count=2`.
- `rlast` on beat 2 of 4 → the line stays invalid, the state returns to IDLE, and the same `req` misses again.
- Assert `rst` mid-FILL with `rvalid` high → `rready=0`, `arvalid=0` and `valid=0` on the next cycle, and no line is validated.
